// File: rtl/sad_best_sel_if.sv
// sad_best_sel_if: candidate SAD stream in, per-window best result out
interface sad_best_sel_if #(
    parameter int DWIDTH   = 8,
    parameter int CAND_NUM = 64
);
    localparam int IW = $clog2(CAND_NUM);
    logic [DWIDTH+7:0] sad;
    logic              sad_vld;
    logic              win_clr;
    logic              early_en;
    logic [DWIDTH+7:0] early_thr;
    logic [DWIDTH+7:0] best_sad;
    logic [IW-1:0]     best_idx;
    logic              best_early;
    logic              best_vld;
    modport master (
        output sad, sad_vld, win_clr, early_en, early_thr,
        input  best_sad, best_idx, best_early, best_vld
    );
    modport slave (
        input  sad, sad_vld, win_clr, early_en, early_thr,
        output best_sad, best_idx, best_early, best_vld
    );
endinterface

// File: rtl/sad_best_sel.sv
// sad_best_sel: minimum-SAD candidate selection per search window with early termination
module sad_best_sel #(
    parameter int DWIDTH   = 8,
    parameter int CAND_NUM = 64
) (
    input logic           clk,
    input logic           rst,
    sad_best_sel_if.slave bus
);
    localparam int IW = $clog2(CAND_NUM);
    localparam logic [IW-1:0] LAST = IW'(CAND_NUM - 1);
    typedef enum logic {ACC, SKIP} state_t;
    state_t            state, state_n;
    logic [IW-1:0]     cnt, cnt_n, min_idx, min_idx_n, c, upd_idx, out_idx;
    logic [DWIDTH+7:0] min_sad, min_sad_n, upd_sad, out_sad;
    logic              in_acc, last, take, hit, fire, out_early;
    // win_clr restarts the window so the coincident beat is candidate 0 in ACC
    assign c       = bus.win_clr ? '0 : cnt;
    assign in_acc  = bus.win_clr || state == ACC;
    assign last    = c == LAST;
    assign take    = c == '0 || bus.sad < min_sad;
    assign hit     = bus.early_en && bus.sad <= bus.early_thr;
    assign upd_sad = take ? bus.sad : min_sad;
    assign upd_idx = take ? c : min_idx;
    // state, counter and running minimum registers plus registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ACC;
            cnt            <= '0;
            min_sad        <= '1;
            min_idx        <= '0;
            bus.best_sad   <= '0;
            bus.best_idx   <= '0;
            bus.best_early <= 1'b0;
            bus.best_vld   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            min_sad      <= min_sad_n;
            min_idx      <= min_idx_n;
            bus.best_vld <= fire;
            if (fire) begin
                bus.best_sad   <= out_sad;
                bus.best_idx   <= out_idx;
                bus.best_early <= out_early;
            end
        end
    end
    // next state: count wraps explicitly at CAND_NUM-1, SKIP entered only on a mid-window early hit
    always_comb begin
        state_n   = bus.win_clr ? ACC : state;
        cnt_n     = c;
        min_sad_n = min_sad;
        min_idx_n = min_idx;
        if (bus.sad_vld) begin
            cnt_n     = last ? '0 : c + 1'b1;
            state_n   = ((in_acc ? hit : state == SKIP) && !last) ? SKIP : ACC;
            min_sad_n = in_acc ? upd_sad : min_sad;
            min_idx_n = in_acc ? upd_idx : min_idx;
        end
    end
    // result select: an early hit reports the beat itself, otherwise the updated minimum
    always_comb begin
        fire      = bus.sad_vld && in_acc && (hit || last);
        out_sad   = hit ? bus.sad : upd_sad;
        out_idx   = hit ? c : upd_idx;
        out_early = hit;
    end
endmodule

// File: doc/sad_best_sel.md
Name: sad_best_sel

Overview:
- Downstream consumer of sad_cal: takes the stream of 16x16 block SAD results (sad/sad_vld) produced for successive motion-search candidates and selects the best (minimum SAD) candidate per search window of CAND_NUM candidates.
- Emits one result per window: best SAD, candidate index, and an early-termination flag.
- Optional early termination: once a candidate's SAD is at or below a programmable threshold, the window result is issued immediately and remaining candidates of that window are discarded.

Parameters:
- DWIDTH, 8, pixel width; SAD width is DWIDTH+8 (matches sad_cal output).
- CAND_NUM, 64, candidates per search window; legal range 2..1024.
- IW, $clog2(CAND_NUM), candidate index width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sad  in  DWIDTH+8  SAD value from sad_cal; sampled only when sad_vld=1.
- sad_vld  in  1  one beat = one candidate; arbitrary gaps allowed; no backpressure.
- win_clr  in  1  synchronous window abort/restart pulse.
- early_en  in  1  enables early termination; sampled per beat.
- early_thr  in  DWIDTH+8  early-termination threshold; sampled per beat.
- best_sad  out  DWIDTH+8  minimum SAD of the completed window.
- best_idx  out  IW  index (0..CAND_NUM-1) of that candidate.
- best_early  out  1  1 = result produced by early termination.
- best_vld  out  1  single-cycle pulse qualifying best_*.

Behaviour:
- Reset (rst=1 at a clock edge): state=ACC, cnt=0, min_sad=all-ones, min_idx=0; best_sad=0, best_idx=0, best_early=0, best_vld=0. Reset mid-window discards all partial results; no output is produced for that window.
- cnt (IW bits) counts accepted sad_vld beats in the current window; a beat's candidate index is the value of cnt when it arrives.
- State ACC, on a beat:
  - Compute cand_sad = sad and cand_idx = cnt.
  - The candidate replaces the running minimum if cnt==0 or sad < min_sad (strict). On ties the lower index is kept.
  - If early_en=1 and sad <= early_thr: output sad and cnt with best_early=1. If cnt != CAND_NUM-1, go to SKIP; otherwise stay in ACC with cnt=0.
  - Else if cnt == CAND_NUM-1: output the updated minimum with best_early=0, set cnt=0, stay in ACC.
  - Otherwise: update min_sad/min_idx and increment cnt.
- State SKIP: beats only advance cnt; no comparison and no output. On the beat with cnt==CAND_NUM-1, set cnt=0 and go to ACC.
- Output timing: best_vld is asserted in the cycle after the triggering beat (latency 1) and lasts exactly 1 cycle. best_sad, best_idx and best_early are registered together and hold their values until the next best_vld.
- Back-to-back windows: the last beat of window N followed by a beat in the next cycle is legal. That next beat is candidate 0 of window N+1, with no bubble required.
- No sad_vld: state, cnt and min hold indefinitely.
- win_clr=1 (priority over everything except rst):
  - Go to ACC, cnt=0, and drop the partial window with no output.
  - A sad_vld coincident with win_clr is treated as candidate 0 of the new window. That means the full ACC rules apply with cnt=0, including early termination.
  - If a best_vld pulse was already scheduled from the previous cycle, it still fires.
- Arithmetic: unsigned compares at full DWIDTH+8 width; no saturation is needed.
- CAND_NUM that is not a power of two: cnt wraps explicitly at CAND_NUM-1, never via natural overflow.

Test Plan:
- CAND_NUM=4, early_en=0, SADs 300,120,120,500 on consecutive cycles -> one best_vld, 1 cycle after the 4th beat, with best_sad=120, best_idx=1, best_early=0.
- CAND_NUM=4, early_en=1, early_thr=50, SADs 200,40,10,5 -> best_vld after the 2nd beat with sad=40, idx=1, early=1. Beats 3-4 produce no output. The next window starts at idx 0 on the 5th beat.
- Two back-to-back windows with random gaps (sad_vld driven low on 0-3 idle cycles) versus a reference model -> exactly one pulse per window with correct min/idx, and no lost or merged windows.
- win_clr asserted with the 3rd beat of a window (SADs 100,90, then 80 with win_clr) -> no result for the aborted window. 80 becomes idx 0 of the new window; following SADs 70,60,95 give best_sad=60, best_idx=2.
- rst asserted mid-window and mid-SKIP -> all outputs 0 the next cycle and no stale best_vld. The following window behaves as from a fresh start.
- Boundaries: all SADs = 0xFFFF -> best_sad=0xFFFF, idx=0. early_thr=0xFFFF with early_en=1 -> every window ends on idx 0.
